msj_multichannel_pd_controller: RTL and testbench

- Time-multiplexed PD controller serving NUM_CH motor channels of the msj platform with one shared multiplier.
- A rising edge on update_controller starts one sweep over all channels, each in position or velocity mode.
- Sits between the encoder/velocity front end and the per-motor PWM generators.
- Generalises the single-channel controller:
  - parametrised width and channel count;
  - shift-based output scaling;
  - busy/done handshake with a pending-request latch;
  - reset of derivative history on mode change.

---
 rtl/msj_multichannel_pd_controller.sv | 249 ++++++++++++++++++++++++
 tb/tb_msj_multichannel_pd_controller.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msj_multichannel_pd_controller.sv
// msj_multichannel_pd_controller: time-multiplexed PD controller, one shared multiplier for NUM_CH channels
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   kp, kd                signed P/D gains, channel c at [c*W +: W]
//   sp                    signed setpoint per channel
//   position, velocity    signed feedback; mode 00 uses position, 01 velocity
//   dead_band             non-negative band; |err| below it forces result 0
//   out_pos_max/neg_max   signed clamps on the result (lower clamp wins)
//   out_shift             arithmetic right shift of the PD sum (6 bits/channel)
//   control_mode          00 position, 01 velocity, 1x disabled (2 bits/channel)
//   update_controller     rising edge requests a sweep over all channels
//   duty                  DUTY_OFFSET - result per channel
//   busy, done            sweep in progress, one-cycle pulse at sweep end
//
// Optional integral term: define MSJ_PD_INTEGRAL_EN to add ports ki/int_max,
// a per-channel accumulator and an extra IMUL state (5 cycles per channel).
module msj_multichannel_pd_controller #(
    parameter int NUM_CH      = 4,
    parameter int W           = 32,
    parameter int DUTY_OFFSET = 50
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_CH*W-1:0]   kp,
    input  logic [NUM_CH*W-1:0]   kd,
    input  logic [NUM_CH*W-1:0]   sp,
    input  logic [NUM_CH*W-1:0]   position,
    input  logic [NUM_CH*W-1:0]   velocity,
    input  logic [NUM_CH*W-1:0]   dead_band,
    input  logic [NUM_CH*W-1:0]   out_pos_max,
    input  logic [NUM_CH*W-1:0]   out_neg_max,
`ifdef MSJ_PD_INTEGRAL_EN
    input  logic [NUM_CH*W-1:0]   ki,
    input  logic [NUM_CH*W-1:0]   int_max,
`endif
    input  logic [NUM_CH*6-1:0]   out_shift,
    input  logic [NUM_CH*2-1:0]   control_mode,
    input  logic                  update_controller,
    output logic [NUM_CH*W-1:0]   duty,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int SW = 2*W + 2;
`ifdef MSJ_PD_INTEGRAL_EN
    localparam int BW = 2*W;
`else
    localparam int BW = W + 1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        PMUL,
        DMUL,
`ifdef MSJ_PD_INTEGRAL_EN
        IMUL,
`endif
        OUT
    } state_t;

    state_t               state;
    logic [CW-1:0]        ch;
    logic                 prev;
    logic                 pending;
    logic                 rise;
    logic signed [W-1:0]  last_err [NUM_CH];
    logic [1:0]           last_mode [NUM_CH];
    logic signed [W-1:0]  err_r;
    logic signed [W:0]    derr_r;
    logic signed [2*W-1:0] pterm_r;
    logic signed [2*W:0]  dterm_r;

    logic signed [W-1:0]  kp_c, kd_c, sp_c, pos_c, vel_c, band_c, pmax_c, nmax_c;
    logic [5:0]           shift_c;
    logic [1:0]           mode_c;

    assign kp_c    = kp[ch*W +: W];
    assign kd_c    = kd[ch*W +: W];
    assign sp_c    = sp[ch*W +: W];
    assign pos_c   = position[ch*W +: W];
    assign vel_c   = velocity[ch*W +: W];
    assign band_c  = dead_band[ch*W +: W];
    assign pmax_c  = out_pos_max[ch*W +: W];
    assign nmax_c  = out_neg_max[ch*W +: W];
    assign shift_c = out_shift[ch*6 +: 6];
    assign mode_c  = control_mode[ch*2 +: 2];
    assign rise    = update_controller & ~prev;

    // Error in W+1 bits, saturated back to W when the sign bits disagree.
    logic signed [W:0]   diff;
    logic signed [W-1:0] err_sat, err_c, last_eff;
    logic signed [W:0]   derr_c;
    logic                chg_c;

    assign diff     = {sp_c[W-1], sp_c} - (mode_c[0] ? {vel_c[W-1], vel_c} : {pos_c[W-1], pos_c});
    assign err_sat  = (diff[W] != diff[W-1]) ? (diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : diff[W-1:0];
    assign err_c    = mode_c[1] ? '0 : err_sat;
    assign chg_c    = mode_c != last_mode[ch];
    assign last_eff = chg_c ? '0 : last_err[ch];
    assign derr_c   = {err_c[W-1], err_c} - {last_eff[W-1], last_eff};

    // Dead-band test on the registered error; abs taken in W+1 bits so the
    // most negative error does not wrap.
    logic signed [W:0] err_x, abs_err;
    logic              in_band;

    assign err_x   = (W+1)'(err_r);
    assign abs_err = err_r[W-1] ? -err_x : err_x;
    assign in_band = abs_err < (W+1)'(band_c);

`ifdef MSJ_PD_INTEGRAL_EN
    logic signed [W-1:0]   ki_c, imax_c, iterm_r;
    logic signed [2*W-1:0] acc [NUM_CH];
    logic signed [2*W-1:0] acc_base, acc_sum, acc_next, lim;
    logic                  chg_r;

    assign ki_c     = ki[ch*W +: W];
    assign imax_c   = int_max[ch*W +: W];
    assign lim      = (2*W)'(imax_c);
    assign acc_base = (chg_r | mode_c[1]) ? '0 : acc[ch];
    assign acc_sum  = acc_base + (in_band ? '0 : (2*W)'(err_r));
    assign acc_next = acc_sum > lim ? lim : acc_sum < -lim ? -lim : acc_sum;
`endif

    // Shared multiplier, operands selected by the current state.
    logic signed [W-1:0]    ma;
    logic signed [BW-1:0]   mb;
    logic signed [W+BW-1:0] prod;

    always_comb begin
        ma = kp_c;
        mb = BW'(err_r);
        if (state == DMUL) begin
            ma = kd_c;
            mb = BW'(derr_r);
        end
`ifdef MSJ_PD_INTEGRAL_EN
        if (state == IMUL) begin
            ma = ki_c;
            mb = acc_next;
        end
`endif
    end

    assign prod = ma * mb;

    // Output stage: shift, upper clamp, then lower clamp so it has priority.
    logic signed [SW-1:0] sum, s, hi, clamp;
    logic [W-1:0]         result, duty_c;

`ifdef MSJ_PD_INTEGRAL_EN
    assign sum = SW'(pterm_r) + SW'(dterm_r) + SW'(iterm_r);
`else
    assign sum = SW'(pterm_r) + SW'(dterm_r);
`endif
    assign s      = sum >>> shift_c;
    assign hi     = s > SW'(pmax_c) ? SW'(pmax_c) : s;
    assign clamp  = hi < SW'(nmax_c) ? SW'(nmax_c) : hi;
    assign result = (in_band | mode_c[1]) ? '0 : clamp[W-1:0];
    assign duty_c = W'(DUTY_OFFSET) - result;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ch      <= '0;
            prev    <= 1'b0;
            pending <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            duty    <= {NUM_CH{W'(DUTY_OFFSET)}};
            err_r   <= '0;
            derr_r  <= '0;
            pterm_r <= '0;
            dterm_r <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                last_err[i]  <= '0;
                last_mode[i] <= 2'b00;
            end
`ifdef MSJ_PD_INTEGRAL_EN
            chg_r   <= 1'b0;
            iterm_r <= '0;
            for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
`endif
        end else begin
            prev <= update_controller;
            done <= 1'b0;
            // Edges while a sweep runs are remembered once; the done cycle
            // counts as busy so its edge is deferred as well.
            if (rise && state != IDLE) pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (pending || (rise && !done)) begin
                        state   <= ERR;
                        ch      <= '0;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end else if (rise) begin
                        pending <= 1'b1;
                    end
                end
                ERR: begin
                    err_r  <= err_c;
                    derr_r <= derr_c;
`ifdef MSJ_PD_INTEGRAL_EN
                    chg_r  <= chg_c;
`endif
                    state  <= PMUL;
                end
                PMUL: begin
                    pterm_r <= prod[2*W-1:0];
                    state   <= DMUL;
                end
                DMUL: begin
                    dterm_r <= prod[2*W:0];
`ifdef MSJ_PD_INTEGRAL_EN
                    state   <= IMUL;
`else
                    state   <= OUT;
`endif
                end
`ifdef MSJ_PD_INTEGRAL_EN
                IMUL: begin
                    acc[ch] <= acc_next;
                    iterm_r <= prod[W-1:0];
                    state   <= OUT;
                end
`endif
                OUT: begin
                    duty[ch*W +: W] <= duty_c;
                    last_err[ch]    <= err_r;
                    last_mode[ch]   <= mode_c;
                    if (ch == CW'(NUM_CH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= ERR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msj_multichannel_pd_controller.sv
// tb_msj_multichannel_pd_controller: directed and randomized checks of the PD controller against a behavioural model
module tb_msj_multichannel_pd_controller;

    localparam int N = 4;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [N*W-1:0] kp, kd, sp, position, velocity, dead_band, out_pos_max, out_neg_max;
    logic [N*6-1:0] out_shift;
    logic [N*2-1:0] control_mode;
    logic           update_controller = 1'b0;
    logic [N*W-1:0] duty;
    logic           busy, done;

    logic signed [W-1:0] kp_a[N], kd_a[N], sp_a[N], pos_a[N], vel_a[N], db_a[N], pm_a[N], nm_a[N];
    logic [5:0]          sh_a[N];
    logic [1:0]          md_a[N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            kp[i*W +: W]          = kp_a[i];
            kd[i*W +: W]          = kd_a[i];
            sp[i*W +: W]          = sp_a[i];
            position[i*W +: W]    = pos_a[i];
            velocity[i*W +: W]    = vel_a[i];
            dead_band[i*W +: W]   = db_a[i];
            out_pos_max[i*W +: W] = pm_a[i];
            out_neg_max[i*W +: W] = nm_a[i];
            out_shift[i*6 +: 6]   = sh_a[i];
            control_mode[i*2 +: 2] = md_a[i];
        end
    end

    msj_multichannel_pd_controller #(.NUM_CH(N), .W(W), .DUTY_OFFSET(50)) dut (
        .clock(clock),
        .reset(reset),
        .kp(kp),
        .kd(kd),
        .sp(sp),
        .position(position),
        .velocity(velocity),
        .dead_band(dead_band),
        .out_pos_max(out_pos_max),
        .out_neg_max(out_neg_max),
        .out_shift(out_shift),
        .control_mode(control_mode),
        .update_controller(update_controller),
        .duty(duty),
        .busy(busy),
        .done(done)
    );

    int checks = 0;
    int errors = 0;

    longint       m_last_err[N];
    logic [1:0]   m_last_mode[N];
    logic [W-1:0] m_duty[N];

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            m_duty[c]      = 32'd50;
            m_last_err[c]  = 0;
            m_last_mode[c] = 2'b00;
        end
    endfunction

    // One sweep computed from the control law with 64-bit arithmetic.
    function automatic void model_sweep();
        longint e, fb, last, p, d, s, r, ae;
        for (int c = 0; c < N; c++) begin
            fb = md_a[c][0] ? longint'(vel_a[c]) : longint'(pos_a[c]);
            if (md_a[c][1]) e = 0;
            else begin
                e = longint'(sp_a[c]) - fb;
                if (e > MAXV) e = MAXV;
                else if (e < MINV) e = MINV;
            end
            last = (md_a[c] != m_last_mode[c]) ? 0 : m_last_err[c];
            p = longint'(kp_a[c]) * e;
            d = longint'(kd_a[c]) * (e - last);
            s = (p + d) >>> sh_a[c];
            ae = e < 0 ? -e : e;
            if (md_a[c][1] || ae < longint'(db_a[c])) r = 0;
            else begin
                r = s;
                if (r > longint'(pm_a[c])) r = longint'(pm_a[c]);
                if (r < longint'(nm_a[c])) r = longint'(nm_a[c]);
            end
            m_duty[c]      = 32'(50 - r);
            m_last_err[c]  = e;
            m_last_mode[c] = md_a[c];
        end
    endfunction

    task automatic start_sweep();
        @(negedge clock);
        update_controller = 1'b1;
        @(negedge clock);
        update_controller = 1'b0;
    endtask

    task automatic set_scenario1();
        kp_a[0] = 2; kd_a[0] = 1; sp_a[0] = 1000; pos_a[0] = 900; vel_a[0] = 0;
        sh_a[0] = 3; db_a[0] = 10; pm_a[0] = 40; nm_a[0] = -40; md_a[0] = 2'b00;
    endtask

    task automatic test_reset();
        for (int c = 0; c < N; c++) begin
            kp_a[c] = 0; kd_a[c] = 0; sp_a[c] = 0; pos_a[c] = 0; vel_a[c] = 0;
            db_a[c] = 0; pm_a[c] = 0; nm_a[c] = 0; sh_a[c] = 0; md_a[c] = 2'b10;
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        for (int c = 0; c < N; c++) begin
            checks++;
            if (duty[c*W +: W] !== 32'd50) begin
                errors++;
                $display("FAIL reset_duty%0d got %0d want 50", c, $signed(duty[c*W +: W]));
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_pos_mode();
        logic [W-1:0] old0;
        set_scenario1();
        old0 = m_duty[0];
        model_sweep();
        start_sweep();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise got %b want 1", busy);
        end
        for (int t = 1; t <= 17; t++) begin
            @(negedge clock);
            checks++;
            if (busy !== (t < 16) || done !== (t == 16)) begin
                errors++;
                $display("FAIL timing t=%0d got busy=%b done=%b want %b %b", t, busy, done, t < 16, t == 16);
            end
            if (t == 3) begin
                checks++;
                if (duty[W-1:0] !== old0) begin
                    errors++;
                    $display("FAIL duty0_early got %0d want %0d", $signed(duty[W-1:0]), $signed(old0));
                end
            end
            if (t == 4) begin
                checks++;
                if (duty[W-1:0] !== m_duty[0]) begin
                    errors++;
                    $display("FAIL duty0_k4 got %0d want %0d", $signed(duty[W-1:0]), $signed(m_duty[0]));
                end
            end
        end
        checks++;
        if (duty[W-1:0] !== 32'd13) begin
            errors++;
            $display("FAIL sweep1_duty0 got %0d want 13", $signed(duty[W-1:0]));
        end
        model_sweep();
        start_sweep();
        repeat (16) @(negedge clock);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL sweep2_done got %b want 1", done);
        end
        checks++;
        if (duty[W-1:0] !== 32'd25) begin
            errors++;
            $display("FAIL sweep2_duty0 got %0d want 25", $signed(duty[W-1:0]));
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (duty[c*W +: W] !== m_duty[c]) begin
                errors++;
                $display("FAIL pos_duty%0d got %0d want %0d", c, $signed(duty[c*W +: W]), $signed(m_duty[c]));
            end
        end
    endtask

    task automatic test_neg_clamp();
        kp_a[1] = 1; kd_a[1] = 0; sp_a[1] = 0; pos_a[1] = 100; vel_a[1] = 0;
        sh_a[1] = 0; db_a[1] = 0; pm_a[1] = 40; nm_a[1] = -30; md_a[1] = 2'b00;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                sh_a[1] = 2;
                nm_a[1] = -40;
            end
            model_sweep();
            start_sweep();
            repeat (16) @(negedge clock);
            checks++;
            if (duty[W +: W] !== (pass == 0 ? 32'd80 : 32'd75)) begin
                errors++;
                $display("FAIL clamp_duty1 pass=%0d got %0d want %0d", pass, $signed(duty[W +: W]), pass == 0 ? 80 : 75);
            end
            for (int c = 0; c < N; c++) begin
                checks++;
                if (duty[c*W +: W] !== m_duty[c]) begin
                    errors++;
                    $display("FAIL clamp_duty%0d got %0d want %0d", c, $signed(duty[c*W +: W]), $signed(m_duty[c]));
                end
            end
        end
    endtask

    task automatic test_mode_switch();
        kp_a[2] = 3; kd_a[2] = 2; sp_a[2] = 5; pos_a[2] = 0; vel_a[2] = 0;
        sh_a[2] = 0; db_a[2] = 10; pm_a[2] = 40; nm_a[2] = -40;
        for (int pass = 0; pass < 3; pass++) begin
            md_a[2] = pass == 1 ? 2'b11 : 2'b01;
            if (pass == 2) db_a[2] = 0;
            model_sweep();
            start_sweep();
            repeat (16) @(negedge clock);
            checks++;
            if (duty[2*W +: W] !== (pass == 2 ? 32'd25 : 32'd50)) begin
                errors++;
                $display("FAIL mode_duty2 pass=%0d got %0d want %0d", pass, $signed(duty[2*W +: W]), pass == 2 ? 25 : 50);
            end
            for (int c = 0; c < N; c++) begin
                checks++;
                if (duty[c*W +: W] !== m_duty[c]) begin
                    errors++;
                    $display("FAIL mode_duty%0d got %0d want %0d", c, $signed(duty[c*W +: W]), $signed(m_duty[c]));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        int pulses = 0;
        model_sweep();
        model_sweep();
        @(negedge clock);
        update_controller = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clock);
            update_controller = (t == 5 || t == 9);
            if (done) begin
                pulses++;
                if (first < 0) first = t;
                else if (second < 0) second = t;
            end
            if (t == 16 || t == 17) begin
                checks++;
                if (busy !== (t == 17)) begin
                    errors++;
                    $display("FAIL b2b_busy t=%0d got %b want %b", t, busy, t == 17);
                end
            end
        end
        checks++;
        if (pulses != 2 || first != 16 || second != 33) begin
            errors++;
            $display("FAIL b2b_done got pulses=%0d at %0d,%0d want 2 at 16,33", pulses, first, second);
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (duty[c*W +: W] !== m_duty[c]) begin
                errors++;
                $display("FAIL b2b_duty%0d got %0d want %0d", c, $signed(duty[c*W +: W]), $signed(m_duty[c]));
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        set_scenario1();
        start_sweep();
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        for (int c = 0; c < N; c++) begin
            checks++;
            if (duty[c*W +: W] !== 32'd50) begin
                errors++;
                $display("FAIL midreset_duty%0d got %0d want 50", c, $signed(duty[c*W +: W]));
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_flags got busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        repeat (20) begin
            @(negedge clock);
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midreset_nodone got %0d pulses want 0", pulses);
        end
        model_sweep();
        start_sweep();
        repeat (16) @(negedge clock);
        checks++;
        if (done !== 1'b1 || duty[W-1:0] !== 32'd13) begin
            errors++;
            $display("FAIL midreset_rerun got done=%b duty0=%0d want 1 13", done, $signed(duty[W-1:0]));
        end
        for (int c = 0; c < N; c++) begin
            checks++;
            if (duty[c*W +: W] !== m_duty[c]) begin
                errors++;
                $display("FAIL midreset_duty%0d got %0d want %0d", c, $signed(duty[c*W +: W]), $signed(m_duty[c]));
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            for (int c = 0; c < N; c++) begin
                if (it == 0 || $urandom_range(1) == 0) md_a[c] = 2'($urandom_range(3));
                kp_a[c]  = int'($urandom_range(40)) - 20;
                kd_a[c]  = int'($urandom_range(40)) - 20;
                sp_a[c]  = int'($urandom_range(4000)) - 2000;
                pos_a[c] = int'($urandom_range(4000)) - 2000;
                vel_a[c] = int'($urandom_range(4000)) - 2000;
                db_a[c]  = int'($urandom_range(150));
                sh_a[c]  = 6'($urandom_range(8));
                pm_a[c]  = int'($urandom_range(500));
                nm_a[c]  = -int'($urandom_range(500));
                if ($urandom_range(5) == 0) nm_a[c] = pm_a[c] + 10;
                if ($urandom_range(7) == 0) begin
                    sp_a[c]  = 32'sh7fffffff;
                    pos_a[c] = -32'sd5000;
                    vel_a[c] = -32'sd5000;
                end
            end
            model_sweep();
            start_sweep();
            repeat (16) @(negedge clock);
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL rand_done it=%0d got %b want 1", it, done);
            end
            for (int c = 0; c < N; c++) begin
                checks++;
                if (duty[c*W +: W] !== m_duty[c]) begin
                    errors++;
                    $display("FAIL rand_duty%0d it=%0d got %0d want %0d", c, it, $signed(duty[c*W +: W]), $signed(m_duty[c]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_pos_mode();
        test_neg_clamp();
        test_mode_switch();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
